// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC load controls and the instruction-memory handshake.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl #(
    parameter int unsigned       N_BITS         = 32,
    parameter logic [N_BITS-1:0] EXC_VECTOR     = 32'h80000180,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_BITS-1:0] pc_value_i,
    output logic [N_BITS-1:0] new_pc_o,
    output logic              pc_enable_o,
    output logic              imem_req_o,
    output logic [N_BITS-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [N_BITS-1:0] imem_data_i,
    output logic [N_BITS-1:0] instr_o,
    output logic              instr_valid_o,
    input  logic              stall_i,
    input  logic              exc_i,
    input  logic              jump_i,
    input  logic [N_BITS-1:0] jump_target_i,
    input  logic              branch_taken_i,
    input  logic [N_BITS-1:0] branch_target_i,
    output logic              fetch_err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DELIVER
    } state_t;

    state_t            state;
    logic              pend_q;
    logic [1:0]        pend_rank_q;
    logic [N_BITS-1:0] pend_tgt_q;

    logic [1:0]        now_rank;
    logic [N_BITS-1:0] now_tgt;
    logic              sel_now;
    logic              best_valid;
    logic [N_BITS-1:0] best_tgt;
    logic              ack_ok;
    logic              timeout;

    // Rank 3/2/1 = exception/jump/branch; 0 means no redirect this cycle.
    always_comb begin
        now_rank = 2'd0;
        now_tgt  = branch_target_i;
        if (exc_i) begin
            now_rank = 2'd3;
            now_tgt  = EXC_VECTOR;
        end else if (jump_i) begin
            now_rank = 2'd2;
            now_tgt  = jump_target_i;
        end else if (branch_taken_i) begin
            now_rank = 2'd1;
            now_tgt  = branch_target_i;
        end
    end

    assign sel_now    = (now_rank != 2'd0) && (!pend_q || now_rank >= pend_rank_q);
    assign best_valid = sel_now || pend_q;
    assign best_tgt   = sel_now ? now_tgt : pend_tgt_q;
    // An ack only counts while a request is actually on the bus.
    assign ack_ok     = (state == S_FETCH) && imem_req_o && imem_ack_i;

    assign imem_addr_o = pc_value_i;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CW-1:0] cnt_q;

    assign timeout = (state == S_FETCH) && !ack_ok && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            fetch_err_o <= 1'b0;
        end else begin
            fetch_err_o <= timeout;
            if (state != S_FETCH || ack_ok || timeout)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout     = 1'b0;
    assign fetch_err_o = 1'b0;
`endif

    always_comb begin
        pc_enable_o = 1'b0;
        new_pc_o    = pc_value_i;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    if (timeout) begin
                        pc_enable_o = 1'b1;
                        new_pc_o    = EXC_VECTOR;
                    end else if (ack_ok && best_valid) begin
                        pc_enable_o = 1'b1;
                        new_pc_o    = best_tgt;
                    end
                end
                S_DELIVER: begin
                    if (now_rank != 2'd0) begin
                        pc_enable_o = 1'b1;
                        new_pc_o    = now_tgt;
                    end else if (!stall_i) begin
                        pc_enable_o = 1'b1;
                        new_pc_o    = pc_value_i + N_BITS'(4);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_IDLE;
            instr_o       <= '0;
            instr_valid_o <= 1'b0;
            imem_req_o    <= 1'b0;
            pend_q        <= 1'b0;
            pend_rank_q   <= '0;
            pend_tgt_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state      <= S_FETCH;
                    imem_req_o <= 1'b1;
                end
                S_FETCH: begin
                    if (timeout) begin
                        imem_req_o  <= 1'b0;
                        pend_q      <= 1'b0;
                        pend_rank_q <= '0;
                    end else if (ack_ok) begin
                        pend_q      <= 1'b0;
                        pend_rank_q <= '0;
                        if (!best_valid) begin
                            instr_o       <= imem_data_i;
                            instr_valid_o <= 1'b1;
                            imem_req_o    <= 1'b0;
                            state         <= S_DELIVER;
                        end
                    end else begin
                        imem_req_o <= 1'b1;
                        if (sel_now) begin
                            pend_q      <= 1'b1;
                            pend_rank_q <= now_rank;
                            pend_tgt_q  <= now_tgt;
                        end
                    end
                end
                S_DELIVER: begin
                    if (now_rank != 2'd0 || !stall_i) begin
                        instr_valid_o <= 1'b0;
                        imem_req_o    <= 1'b1;
                        state         <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed + randomized bench for pc_fetch_ctrl against a transaction-level model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] EXC = 32'h80000180;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_value_i, new_pc_o, imem_addr_o, imem_data_i, instr_o;
    logic [31:0] jump_target_i, branch_target_i;
    logic        pc_enable_o, imem_req_o, imem_ack_i, instr_valid_o, stall_i;
    logic        exc_i, jump_i, branch_taken_i, fetch_err_o;

    always #5 clk = ~clk;

    pc_fetch_ctrl #(.N_BITS(32), .EXC_VECTOR(EXC), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .pc_value_i(pc_value_i), .new_pc_o(new_pc_o),
        .pc_enable_o(pc_enable_o), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i), .instr_o(instr_o),
        .instr_valid_o(instr_valid_o), .stall_i(stall_i), .exc_i(exc_i), .jump_i(jump_i),
        .jump_target_i(jump_target_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .fetch_err_o(fetch_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: m_wait = a fetch is outstanding, m_have = a word is held for decode.
    bit          m_run, m_wait, m_have, m_drop, m_err;
    logic [31:0] m_instr, m_ptgt;
    int          m_prank, m_cnt;
    bit          e_en;
    logic [31:0] e_npc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_wait = 0; m_have = 0; m_drop = 0; m_err = 0;
        m_prank = 0; m_cnt = 0; m_instr = '0; m_ptgt = '0;
    endtask

    task automatic cycle(input string tag);
        int          rank;
        logic [31:0] tgt;
        bit          acked, tmo;
        #1;
        rank = exc_i ? 3 : jump_i ? 2 : branch_taken_i ? 1 : 0;
        tgt  = exc_i ? EXC : jump_i ? jump_target_i : branch_target_i;
        chk({tag, ".req"}, imem_req_o, m_wait && !m_drop);
        if (m_wait && !m_drop) chk({tag, ".addr"}, imem_addr_o, pc_value_i);
        chk({tag, ".valid"}, instr_valid_o, m_have);
        if (m_have) chk({tag, ".instr"}, instr_o, m_instr);
        chk({tag, ".err"}, fetch_err_o, m_err);

        m_err = 0;
        e_en  = 0;
        e_npc = pc_value_i;
        acked = imem_ack_i && m_wait && !m_drop;
        if (!reset) begin
            model_clear();
        end else if (!m_run) begin
            m_run = 1; m_wait = 1; m_cnt = 0;
        end else if (m_have) begin
            if (rank > 0) begin
                e_en = 1; e_npc = tgt;
            end else if (!stall_i) begin
                e_en = 1; e_npc = pc_value_i + 32'd4;
            end
            if (e_en) begin
                m_have = 0; m_wait = 1; m_cnt = 0; m_drop = 0;
            end
        end else begin
            tmo = TMO_ON && !acked && (m_cnt == 15);
            if (rank > 0 && rank >= m_prank) begin
                m_prank = rank; m_ptgt = tgt;
            end
            m_drop = 0;
            if (tmo) begin
                e_en = 1; e_npc = EXC; m_prank = 0; m_err = 1; m_drop = 1; m_cnt = 0;
            end else if (acked) begin
                m_cnt = 0;
                if (m_prank > 0) begin
                    e_en = 1; e_npc = m_ptgt; m_prank = 0;
                end else begin
                    m_have = 1; m_instr = imem_data_i; m_wait = 0;
                end
            end else begin
                m_cnt++;
            end
        end
        chk({tag, ".pc_en"}, pc_enable_o, e_en);
        chk({tag, ".new_pc"}, new_pc_o, e_npc);
        @(posedge clk);
        #1;
        if (e_en) pc_value_i = e_npc;
    endtask

    initial begin
        logic [31:0] d;
        int          errs;
        reset = 0; pc_value_i = 32'h00400000; imem_ack_i = 0; imem_data_i = '0;
        stall_i = 0; exc_i = 0; jump_i = 0; branch_taken_i = 0;
        jump_target_i = '0; branch_target_i = '0;
        model_clear();
        @(posedge clk);
        #1;
        cycle("rst");
        chk("rst.instr", instr_o, 32'h0);

        // Basic fetch / deliver / consume.
        reset = 1;
        cycle("t1.idle");
        chk("t1.req", imem_req_o, 1'b1);
        chk("t1.addr", imem_addr_o, 32'h00400000);
        d = $urandom; imem_ack_i = 1; imem_data_i = d;
        cycle("t1.ack");
        imem_ack_i = 0;
        chk("t1.instr", instr_o, d);
        #1;
        chk("t1.en", pc_enable_o, 1'b1);
        chk("t1.npc", new_pc_o, 32'h00400004);
        cycle("t1.consume");
        chk("t1.addr2", imem_addr_o, 32'h00400004);

        // Stall holds the delivered word.
        d = $urandom; imem_ack_i = 1; imem_data_i = d;
        cycle("t2.ack");
        imem_ack_i = 0; stall_i = 1;
        for (int i = 0; i < 5; i++) begin
            cycle("t2.stall");
            chk("t2.instr", instr_o, d);
        end
        stall_i = 0;
        #1;
        chk("t2.npc", new_pc_o, 32'h00400008);
        cycle("t2.release");

        // Branch latched during fetch squashes the word.
        branch_taken_i = 1; branch_target_i = 32'h00400100;
        cycle("t3.br");
        branch_taken_i = 0; branch_target_i = '0;
        cycle("t3.w1");
        cycle("t3.w2");
        imem_ack_i = 1; imem_data_i = $urandom;
        #1;
        chk("t3.npc", new_pc_o, 32'h00400100);
        cycle("t3.ack");
        imem_ack_i = 0;
        chk("t3.valid", instr_valid_o, 1'b0);
        chk("t3.addr", imem_addr_o, 32'h00400100);

        // Coincident redirects while stalled in deliver: exception wins.
        imem_ack_i = 1; imem_data_i = $urandom;
        cycle("t4.ack");
        imem_ack_i = 0; stall_i = 1;
        cycle("t4.stall");
        exc_i = 1; jump_i = 1; jump_target_i = 32'h00400040;
        branch_taken_i = 1; branch_target_i = 32'h00400100;
        #1;
        chk("t4.npc", new_pc_o, EXC);
        cycle("t4.redir");
        exc_i = 0; jump_i = 0; branch_taken_i = 0; stall_i = 0;
        chk("t4.valid", instr_valid_o, 1'b0);

        // PC+4 wraps; reset mid-fetch abandons the request.
        imem_ack_i = 1; imem_data_i = $urandom;
        cycle("t5.ack");
        imem_ack_i = 0;
        pc_value_i = 32'hFFFFFFFC;
        #1;
        chk("t5.wrap", new_pc_o, 32'h00000000);
        cycle("t5.consume");
        reset = 0;
        cycle("t5.rst");
        reset = 1; imem_ack_i = 1; imem_data_i = $urandom;
        cycle("t5.late");
        imem_ack_i = 0;
        cycle("t5.after");
        chk("t5.valid", instr_valid_o, 1'b0);

        // No ack: watchdog when enabled, otherwise an indefinite wait.
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            cycle("t6.wait");
            if (fetch_err_o) errs++;
        end
        if (TMO_ON) chk("t6.errs", (errs >= 2 && errs <= 3), 1'b1);
        else        chk("t6.errs", errs, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(199) != 0);
            if (!reset) pc_value_i = 32'h00400000;
            stall_i        = ($urandom_range(2) == 0);
            imem_ack_i     = ($urandom_range(2) == 0);
            imem_data_i    = $urandom;
            exc_i          = ($urandom_range(22) == 0);
            jump_i         = ($urandom_range(10) == 0);
            branch_taken_i = ($urandom_range(6) == 0);
            jump_target_i   = {$urandom_range(32'h3FFFFFFF), 2'b00};
            branch_target_i = {$urandom_range(32'h3FFFFFFF), 2'b00};
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
